// File: rtl/imem_arb_pkg.sv
// imem_arbiter shared types: FSM states, requester ids, default widths.
// Imported by the arbiter, its interface and the watchdog.
package imem_arb_pkg;

   localparam int DefAddrW = 20;
   localparam int DefDataW = 20;

   typedef enum logic [1:0] {
      IDLE,
      F_WAIT,
      L_WAIT
   } arbState_e;

   typedef enum logic {
      REQ_F,
      REQ_L
   } reqId_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory bundle of imem_arbiter.
// slave = arbiter view, master = fetch/loader/memory view.
interface imem_arbiter_if
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W = DefAddrW,
   parameter int DATA_W = DefDataW
);

   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_kill;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;
   logic              f_stall;

   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_done;
   logic [DATA_W-1:0] l_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   logic              err;

   modport slave (
      input  f_req, f_addr, f_kill,
      output f_gnt, f_rvalid, f_rdata, f_stall,
      input  l_req, l_we, l_addr, l_wdata,
      output l_gnt, l_done, l_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata,
      output err
   );

   modport master (
      output f_req, f_addr, f_kill,
      input  f_gnt, f_rvalid, f_rdata, f_stall,
      output l_req, l_we, l_addr, l_wdata,
      input  l_gnt, l_done, l_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata,
      input  err
   );

endinterface

// File: rtl/imem_arb_watchdog.sv
// Wait-state watchdog: aborts an access after TIMEOUT_CYC cycles
// without mem_ready. Only built with IMEM_ARB_TIMEOUT_EN.
module imem_arb_watchdog #(
   parameter int TIMEOUT_CYC = 255
)(
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   output logic abort
);

   localparam int CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

   logic [CntW-1:0] cnt;

   assign abort = active & ~ready & (cnt == LastCnt);

   // count unanswered wait cycles, restart on completion or abort
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!active || ready || abort) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: loader-priority with bounded bursts,
// fetch kill on redirect. Optional watchdog: IMEM_ARB_TIMEOUT_EN.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W      = DefAddrW,
   parameter int DATA_W      = DefDataW,
   parameter int LOAD_BURST  = 4,
   parameter int TIMEOUT_CYC = 255
)(
   input logic           clk,
   input logic           rst,
   imem_arbiter_if.slave bus
);

   localparam int BurstW = $clog2(LOAD_BURST + 1);
   localparam logic [BurstW-1:0] BurstMax = BurstW'(LOAD_BURST);

   arbState_e state, nextState;
   reqId_e    winner;

   logic              pickF, pickL;
   logic              waiting, arbEn, abort;
   logic              fDone, lDone, fDeliver;
   logic              burstFull;
   logic [BurstW-1:0] burstCnt;
   logic              dropQ;

   logic              memReqQ, memWeQ;
   logic [ADDR_W-1:0] memAddrQ;
   logic [DATA_W-1:0] memWdataQ;
   logic              fGntQ, lGntQ, fRvalidQ, lDoneQ, errQ;
   logic [DATA_W-1:0] fRdataQ, lRdataQ;

   assign waiting   = (state != IDLE);
   assign arbEn     = !waiting || bus.mem_ready;
   assign burstFull = (burstCnt == BurstMax);
   assign fDone     = (state == F_WAIT) && bus.mem_ready;
   assign lDone     = (state == L_WAIT) && bus.mem_ready;
   assign fDeliver  = fDone && !dropQ && !bus.f_kill;

`ifdef IMEM_ARB_TIMEOUT_EN
   imem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) uWatchdog (
      .clk    (clk),
      .rst    (rst),
      .active (waiting),
      .ready  (bus.mem_ready),
      .abort  (abort)
   );
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT_CYC;
   assign abort = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // arbitration and next state
   always_comb begin
      nextState = state;
      pickF     = 1'b0;
      pickL     = 1'b0;
      winner    = REQ_F;
      if (arbEn) begin
         nextState = IDLE;
         if (bus.f_req && (!bus.l_req || burstFull)) begin
            pickF     = 1'b1;
            winner    = REQ_F;
            nextState = F_WAIT;
         end else if (bus.l_req) begin
            pickL     = 1'b1;
            winner    = REQ_L;
            nextState = L_WAIT;
         end
      end else if (abort) begin
         nextState = IDLE;
      end
   end

   // memory command, grant/completion pulses, burst and kill tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memReqQ   <= 1'b0;
         memWeQ    <= 1'b0;
         memAddrQ  <= '0;
         memWdataQ <= '0;
         fGntQ     <= 1'b0;
         lGntQ     <= 1'b0;
         fRvalidQ  <= 1'b0;
         lDoneQ    <= 1'b0;
         errQ      <= 1'b0;
         fRdataQ   <= '0;
         lRdataQ   <= '0;
         burstCnt  <= '0;
         dropQ     <= 1'b0;
      end else begin
         memReqQ  <= (nextState != IDLE);
         fGntQ    <= pickF;
         lGntQ    <= pickL;
         fRvalidQ <= fDeliver;
         lDoneQ   <= lDone;
         errQ     <= abort;
         if (pickF || pickL) begin
            memWeQ    <= (winner == REQ_L) && bus.l_we;
            memAddrQ  <= (winner == REQ_L) ? bus.l_addr : bus.f_addr;
            memWdataQ <= (winner == REQ_L) ? bus.l_wdata : '0;
         end
         if (fDeliver) begin
            fRdataQ <= bus.mem_rdata;
         end
         if (lDone) begin
            lRdataQ <= bus.mem_rdata;
         end
         if (pickF) begin
            burstCnt <= '0;
         end else if (pickL) begin
            if (!bus.f_req) begin
               burstCnt <= '0;
            end else if (!burstFull) begin
               burstCnt <= burstCnt + 1'b1;
            end
         end
         if (fDone || abort) begin
            dropQ <= 1'b0;
         end else if ((state == F_WAIT) && bus.f_kill) begin
            dropQ <= 1'b1;
         end
      end
   end

   assign bus.mem_req   = memReqQ;
   assign bus.mem_we    = memWeQ;
   assign bus.mem_addr  = memAddrQ;
   assign bus.mem_wdata = memWdataQ;
   assign bus.f_gnt     = fGntQ;
   assign bus.l_gnt     = lGntQ;
   assign bus.f_rvalid  = fRvalidQ;
   assign bus.l_done    = lDoneQ;
   assign bus.f_rdata   = fRdataQ;
   assign bus.l_rdata   = lRdataQ;
   assign bus.err       = errQ;
   assign bus.f_stall   = bus.f_req & ~fRvalidQ;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

- Shares the single-port instruction memory between the fetch stage (read-only) and the program loader (read/write).
- Loader has priority for boot and patching, with a bounded-burst fairness rule so fetch is never starved.
- Fetch accesses can be killed on a branch redirect: the returned word is dropped, not delivered.
- Sits between `fetch_cycle` and the instruction memory.

## Interface
- `ADDR_W`, 20: memory address width (matches PC width).
- `DATA_W`, 20: instruction/data word width.
- `LOAD_BURST`, 4: max consecutive loader grants while a fetch request is pending.
- `TIMEOUT_CYC`, 255: wait-cycle limit for the watchdog (used only when the macro is set).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request, held until `f_rvalid`.
- `f_addr` in ADDR_W: fetch address (PCF).
- `f_kill` in 1: redirect (PCSrcE); drop any outstanding fetch.
- `f_gnt` out 1: one-cycle pulse, fetch access launched.
- `f_rvalid` out 1: one-cycle pulse, `f_rdata` valid.
- `f_rdata` out DATA_W: fetched word.
- `f_stall` out 1: `f_req & ~f_rvalid`, combinational; drives StallF.
- `l_req` in 1: loader request, held until `l_done`.
- `l_we` in 1: loader write enable.
- `l_addr` in ADDR_W: loader address.
- `l_wdata` in DATA_W: loader write data.
- `l_gnt` out 1: one-cycle pulse, loader access launched.
- `l_done` out 1: one-cycle pulse, loader access complete.
- `l_rdata` out DATA_W: loader read data (valid with `l_done`, when `l_we=0`).
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_ready` in 1: memory access complete this cycle.
- `mem_rdata` in DATA_W: memory read data (valid with `mem_ready`).
- `err` out 1: watchdog abort pulse; tied 0 without the macro.

## Operation
- FSM states: `IDLE`, `F_WAIT`, `L_WAIT`.
- Arbitration occurs in `IDLE`, and also in a WAIT state on the cycle `mem_ready`=1 (back-to-back, no idle gap).
- Arbitration rule:
  - Loader wins, unless `f_req`=1 and `burst_cnt`==`LOAD_BURST`; then fetch wins.
  - `burst_cnt` increments on a loader grant while `f_req`=1.
  - `burst_cnt` clears on any fetch grant, or on a loader grant with `f_req`=0.
  - `burst_cnt` saturates at `LOAD_BURST`.
- On grant:
  - `mem_addr`/`mem_we`/`mem_wdata` are registered from the winner; fetch forces `mem_we`=0.
  - `mem_req`=1 and the matching `*_gnt` pulse appear the cycle after arbitration.
  - `mem_req` is held with stable address/data until `mem_ready` is sampled 1.
- Completion:
  - On the edge after `mem_ready`, `f_rvalid` or `l_done` pulses with registered `mem_rdata`.
  - Write completion still pulses `l_done`; `l_rdata` is don't-care.
- Kill:
  - `f_kill`=1 in any `F_WAIT` cycle, including the `mem_ready` cycle, sets `drop`.
  - The completion then yields no `f_rvalid`; `drop` clears at completion.
  - `f_kill` in `IDLE` or `L_WAIT` has no effect.
- Reset (async, any time): state `IDLE`, `mem_req`=0, all pulses 0, data outputs 0, `burst_cnt`=0, `drop`=0. An in-flight access is abandoned.

## Timing
- Min fetch latency: `f_req` in cycle 0 → `mem_req`/`f_gnt` in cycle 1 → `mem_ready` in cycle 1 → `f_rvalid` in cycle 2.
- Zero-wait memory gives throughput of 1 access/cycle.
- Each added wait state adds one cycle.
- `f_rvalid`/`l_done` never coincide; at most one of `f_gnt`/`l_gnt` is asserted per cycle.

## Configuration
- `IMEM_ARB_TIMEOUT_EN` defined:
  - A wait counter runs in `F_WAIT`/`L_WAIT`.
  - On reaching `TIMEOUT_CYC` without `mem_ready`: `mem_req` drops, the FSM returns to `IDLE`, `err` pulses one cycle.
  - No `f_rvalid`/`l_done` is issued for the aborted access; the requester re-arbitrates while its request is still held.
- Undefined: no counter; `err`=0; waits are unbounded.

## Structure
- `imem_arb_pkg`: state enum, default `ADDR_W`/`DATA_W`, requester-id enum (`REQ_F`, `REQ_L`).
- Sub-module `imem_arb_watchdog` (counter + abort pulse) is instantiated only under `IMEM_ARB_TIMEOUT_EN`.

## Test plan
- Fetch only, `f_addr`=20'h00010, zero-wait memory returning 20'hABCDE → `mem_req` in cycle 1, `f_rvalid`=1 with `f_rdata`=20'hABCDE in cycle 2; `f_stall`=1 in cycles 0–1.
- `f_req` and `l_req` both held continuously, `LOAD_BURST`=4 → grant sequence L,L,L,L,F,L,L,L,L,F.
- Fetch with 3 wait states, `f_kill` pulsed in the 2nd wait cycle → no `f_rvalid`; the next fetch to 20'h00040 returns normally.
- Loader write 20'h12345 to 20'h00020, then fetch 20'h00020 → `l_done`, then `f_rdata`=20'h12345.
- `rst` asserted mid-`F_WAIT` → `mem_req` and all outputs 0 immediately; after release, the state is `IDLE`.
- With `IMEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=8, `mem_ready` held 0 → `err` pulses after 8 wait cycles, `mem_req` drops, and no `f_rvalid`.
